l2_cache_tag_sram: RTL and testbench



---
 rtl/l2_cache_tag_sram_pkg.sv | 24 ++
 rtl/l2_cache_tag_sram_if.sv | 58 +++++
 rtl/l2_cache_tag_sram_sweeper.sv | 52 +++++
 rtl/sram_1r1w.sv | 28 ++
 rtl/l2_cache_tag_sram.sv | 163 ++++++++++++++++
 tb/tb_l2_cache_tag_sram.sv | 356 +++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/l2_cache_tag_sram_pkg.sv
// Shared types for the L2 tag-lookup stage: default geometry, way/set/tag types, sweep FSM states.
package l2_cache_tag_sram_pkg;

    localparam int unsigned L2_WAYS          = 4;
    localparam int unsigned L2_SETS          = 256;
    localparam int unsigned L2_TAG_WIDTH     = 18;
    localparam int unsigned L2_PAYLOAD_WIDTH = 64;
    localparam int unsigned L2_SET_BITS      = $clog2(L2_SETS);

    typedef logic [L2_WAYS-1:0]      l2_way_mask_t;
    typedef logic [L2_SET_BITS-1:0]  l2_set_t;
    typedef logic [L2_TAG_WIDTH-1:0] l2_tag_t;

    typedef struct packed {
        logic    valid;
        l2_tag_t tag;
    } l2_tag_entry_t;

    typedef enum logic {
        SWEEP = 1'b0,
        RUN   = 1'b1
    } sweep_state_e;

endpackage

// File: rtl/l2_cache_tag_sram_if.sv
// Request, update, flush and lookup-result bundle between the L2 arbiter side and the tag stage.
interface l2_cache_tag_sram_if
    import l2_cache_tag_sram_pkg::*;
#(
    parameter int unsigned NUM_WAYS      = L2_WAYS,
    parameter int unsigned NUM_SETS      = L2_SETS,
    parameter int unsigned TAG_WIDTH     = L2_TAG_WIDTH,
    parameter int unsigned PAYLOAD_WIDTH = L2_PAYLOAD_WIDTH
);
    localparam int unsigned SET_BITS = $clog2(NUM_SETS);

    logic                          req_valid;
    logic [SET_BITS-1:0]           req_set;
    logic [TAG_WIDTH-1:0]          req_tag;
    logic [PAYLOAD_WIDTH-1:0]      req_payload;
    logic                          req_ready;
    logic                          stall;

    logic [NUM_WAYS-1:0]           upd_tag_en;
    logic [SET_BITS-1:0]           upd_tag_set;
    logic [TAG_WIDTH-1:0]          upd_tag;
    logic                          upd_valid;
    logic [NUM_WAYS-1:0]           upd_dirty_en;
    logic [SET_BITS-1:0]           upd_dirty_set;
    logic                          upd_dirty_value;

    logic                          flush_req;
    logic                          flush_busy;

    logic                          out_valid;
    logic [SET_BITS-1:0]           out_set;
    logic [TAG_WIDTH-1:0]          out_tag;
    logic [PAYLOAD_WIDTH-1:0]      out_payload;
    logic [NUM_WAYS-1:0]           out_way_valid;
    logic [NUM_WAYS-1:0]           out_way_dirty;
    logic [NUM_WAYS*TAG_WIDTH-1:0] out_way_tag;
    logic [NUM_WAYS-1:0]           out_hit;
    logic                          out_hit_any;

    modport master (
        output req_valid, req_set, req_tag, req_payload, stall,
        output upd_tag_en, upd_tag_set, upd_tag, upd_valid,
        output upd_dirty_en, upd_dirty_set, upd_dirty_value, flush_req,
        input  req_ready, flush_busy,
        input  out_valid, out_set, out_tag, out_payload,
        input  out_way_valid, out_way_dirty, out_way_tag, out_hit, out_hit_any
    );

    modport slave (
        input  req_valid, req_set, req_tag, req_payload, stall,
        input  upd_tag_en, upd_tag_set, upd_tag, upd_valid,
        input  upd_dirty_en, upd_dirty_set, upd_dirty_value, flush_req,
        output req_ready, flush_busy,
        output out_valid, out_set, out_tag, out_payload,
        output out_way_valid, out_way_dirty, out_way_tag, out_hit, out_hit_any
    );

endinterface

// File: rtl/l2_cache_tag_sram_sweeper.sv
// Sweep controller: walks every set after reset or flush, then hands the arrays to lookups.
module l2_tag_sweeper
    import l2_cache_tag_sram_pkg::*;
#(
    parameter int unsigned NUM_SETS = L2_SETS,
    parameter int unsigned SET_BITS = $clog2(NUM_SETS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush_req,
    output sweep_state_e        state,
    output logic [SET_BITS-1:0] sweep_set,
    output logic                flush_busy
);

    sweep_state_e        state_d;
    logic [SET_BITS-1:0] sweep_set_d;

    // State, counter and busy flag registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= SWEEP;
            sweep_set  <= '0;
            flush_busy <= 1'b1;
        end else begin
            state      <= state_d;
            sweep_set  <= sweep_set_d;
            flush_busy <= (state_d == SWEEP);
        end
    end

    // Next state: count through all sets, wrap to 0 on exit; flush only restarts from RUN.
    always_comb begin
        state_d     = state;
        sweep_set_d = sweep_set;
        case (state)
            SWEEP: begin
                sweep_set_d = sweep_set + SET_BITS'(1);
                if (sweep_set == SET_BITS'(NUM_SETS - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (flush_req) begin
                    state_d = SWEEP;
                end
            end
            default: state_d = SWEEP;
        endcase
    end

endmodule

// File: rtl/sram_1r1w.sv
// One-read one-write SRAM with registered read; a same-address write in the read cycle is bypassed.
module sram_1r1w #(
    parameter int unsigned WIDTH     = 1,
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned ADDR_BITS = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [WIDTH-1:0]     rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Array write and read-enable-gated read with write-first bypass.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
        end
    end

endmodule

// File: rtl/l2_cache_tag_sram.sv
// L2 tag-lookup stage: per-way tag/valid and dirty SRAMs, sweep clear, held-output forwarding, hit vector.
module l2_cache_tag_sram
    import l2_cache_tag_sram_pkg::*;
#(
    parameter int unsigned NUM_WAYS      = L2_WAYS,
    parameter int unsigned NUM_SETS      = L2_SETS,
    parameter int unsigned TAG_WIDTH     = L2_TAG_WIDTH,
    parameter int unsigned PAYLOAD_WIDTH = L2_PAYLOAD_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    l2_cache_tag_sram_if.slave bus
);

    localparam int unsigned SET_BITS = $clog2(NUM_SETS);
    localparam int unsigned ENTRY_W  = TAG_WIDTH + 1;

    sweep_state_e        state;
    logic [SET_BITS-1:0] sweep_set;
    logic                sweep_c;
    logic                accept_c;
    logic                fwd_c;

    logic [NUM_WAYS-1:0] tag_we_c;
    logic [SET_BITS-1:0] tag_waddr_c;
    logic [ENTRY_W-1:0]  tag_wdata_c;
    logic [NUM_WAYS-1:0] dirty_we_c;
    logic [SET_BITS-1:0] dirty_waddr_c;
    logic                dirty_wdata_c;

    logic [ENTRY_W-1:0]  tag_rdata [NUM_WAYS];
    logic [NUM_WAYS-1:0] dirty_rdata;

    // Forwarded updates captured while the output is held; they override the SRAM read data.
    logic [NUM_WAYS-1:0] tag_ovr_mask;
    logic [ENTRY_W-1:0]  tag_ovr [NUM_WAYS];
    logic [NUM_WAYS-1:0] dirty_ovr_mask;
    logic [NUM_WAYS-1:0] dirty_ovr;

    logic [ENTRY_W-1:0]  entry_c;
    logic [NUM_WAYS-1:0] hit_c;

    l2_tag_sweeper #(
        .NUM_SETS (NUM_SETS),
        .SET_BITS (SET_BITS)
    ) u_sweeper (
        .clk        (clk),
        .reset      (reset),
        .flush_req  (bus.flush_req),
        .state      (state),
        .sweep_set  (sweep_set),
        .flush_busy (bus.flush_busy)
    );

    assign sweep_c       = (state == SWEEP);
    assign bus.req_ready = (state == RUN) && !bus.stall;
    assign accept_c      = bus.req_valid && bus.req_ready;
    // Forward only what actually reaches the arrays; the sweep owns the write port while active.
    assign fwd_c         = bus.stall && bus.out_valid && !sweep_c;

    // Write-port mux: sweep clear takes priority over caller updates.
    always_comb begin
        tag_we_c      = bus.upd_tag_en;
        tag_waddr_c   = bus.upd_tag_set;
        tag_wdata_c   = {bus.upd_valid, bus.upd_tag};
        dirty_we_c    = bus.upd_dirty_en;
        dirty_waddr_c = bus.upd_dirty_set;
        dirty_wdata_c = bus.upd_dirty_value;
        if (sweep_c) begin
            tag_we_c      = '1;
            tag_waddr_c   = sweep_set;
            tag_wdata_c   = '0;
            dirty_we_c    = '1;
            dirty_waddr_c = sweep_set;
            dirty_wdata_c = 1'b0;
        end
    end

    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
        sram_1r1w #(
            .WIDTH (ENTRY_W),
            .DEPTH (NUM_SETS)
        ) u_tag_ram (
            .clk   (clk),
            .we    (tag_we_c[w]),
            .waddr (tag_waddr_c),
            .wdata (tag_wdata_c),
            .re    (accept_c),
            .raddr (bus.req_set),
            .rdata (tag_rdata[w])
        );

        sram_1r1w #(
            .WIDTH (1),
            .DEPTH (NUM_SETS)
        ) u_dirty_ram (
            .clk   (clk),
            .we    (dirty_we_c[w]),
            .waddr (dirty_waddr_c),
            .wdata (dirty_wdata_c),
            .re    (accept_c),
            .raddr (bus.req_set),
            .rdata (dirty_rdata[w])
        );
    end

    // Output stage: load on accept, drop valid when idle, hold and absorb same-set updates on stall.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.out_valid   <= 1'b0;
            bus.out_set     <= '0;
            bus.out_tag     <= '0;
            bus.out_payload <= '0;
            tag_ovr_mask    <= '0;
            dirty_ovr_mask  <= '0;
            dirty_ovr       <= '0;
            for (int unsigned w = 0; w < NUM_WAYS; w++) begin
                tag_ovr[w] <= '0;
            end
        end else if (accept_c) begin
            bus.out_valid   <= 1'b1;
            bus.out_set     <= bus.req_set;
            bus.out_tag     <= bus.req_tag;
            bus.out_payload <= PAYLOAD_WIDTH'(bus.req_payload);
            tag_ovr_mask    <= '0;
            dirty_ovr_mask  <= '0;
        end else if (!bus.stall) begin
            bus.out_valid <= 1'b0;
        end else if (fwd_c) begin
            for (int unsigned w = 0; w < NUM_WAYS; w++) begin
                if (bus.upd_tag_en[w] && (bus.upd_tag_set == bus.out_set)) begin
                    tag_ovr_mask[w] <= 1'b1;
                    tag_ovr[w]      <= {bus.upd_valid, bus.upd_tag};
                end
                if (bus.upd_dirty_en[w] && (bus.upd_dirty_set == bus.out_set)) begin
                    dirty_ovr_mask[w] <= 1'b1;
                    dirty_ovr[w]      <= bus.upd_dirty_value;
                end
            end
        end
    end

    // Per-way state and hit vector for the registered request; zero while no result is held.
    always_comb begin
        bus.out_way_valid = '0;
        bus.out_way_dirty = '0;
        bus.out_way_tag   = '0;
        hit_c             = '0;
        entry_c           = '0;
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            if (bus.out_valid) begin
                entry_c = tag_ovr_mask[w] ? tag_ovr[w] : tag_rdata[w];
                bus.out_way_valid[w]                      = entry_c[TAG_WIDTH];
                bus.out_way_tag[w*TAG_WIDTH +: TAG_WIDTH] = entry_c[TAG_WIDTH-1:0];
                bus.out_way_dirty[w] = dirty_ovr_mask[w] ? dirty_ovr[w] : dirty_rdata[w];
                hit_c[w] = entry_c[TAG_WIDTH] && (entry_c[TAG_WIDTH-1:0] == bus.out_tag);
            end
        end
        bus.out_hit     = hit_c;
        bus.out_hit_any = |hit_c;
    end

endmodule

// File: tb/tb_l2_cache_tag_sram.sv
// Directed bench for the L2 tag-lookup stage.
module tb_l2_cache_tag_sram;
    import l2_cache_tag_sram_pkg::*;

    localparam int unsigned WAYS = 4;
    localparam int unsigned SETS = 256;
    localparam int unsigned TW   = 18;
    localparam int unsigned PW   = 64;
    localparam int unsigned SB   = $clog2(SETS);

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    l2_cache_tag_sram_if #(
        .NUM_WAYS(WAYS), .NUM_SETS(SETS), .TAG_WIDTH(TW), .PAYLOAD_WIDTH(PW)
    ) bus ();

    l2_cache_tag_sram #(
        .NUM_WAYS(WAYS), .NUM_SETS(SETS), .TAG_WIDTH(TW), .PAYLOAD_WIDTH(PW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // More than one matching way is never legal.
    always @(negedge clk) begin
        if (reset === 1'b1 && $countones(bus.out_hit) > 1) begin
            n_fail++;
            $display("FAIL multi_hit out_hit=%b required one-hot or zero", bus.out_hit);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.req_valid       = 1'b0;
        bus.req_set         = '0;
        bus.req_tag         = '0;
        bus.req_payload     = '0;
        bus.stall           = 1'b0;
        bus.upd_tag_en      = '0;
        bus.upd_tag_set     = '0;
        bus.upd_tag         = '0;
        bus.upd_valid       = 1'b0;
        bus.upd_dirty_en    = '0;
        bus.upd_dirty_set   = '0;
        bus.upd_dirty_value = 1'b0;
        bus.flush_req       = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.out_hit_any !== 1'b0 || bus.out_way_valid !== 4'b0 ||
            bus.out_payload !== 64'h0 || bus.out_way_tag !== 72'h0) begin
            n_fail++;
            $display("FAIL reset_outputs out_valid=%b hit_any=%b way_valid=%b payload=%h required all zero",
                     bus.out_valid, bus.out_hit_any, bus.out_way_valid, bus.out_payload);
        end
        n_checks++;
        if (bus.flush_busy !== 1'b1 || bus.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy flush_busy=%b req_ready=%b required 1/0", bus.flush_busy, bus.req_ready);
        end
        reset = 1'b1;
        for (int k = 1; k <= int'(SETS); k++) begin
            tick();
            n_checks++;
            if (bus.req_ready !== (k >= int'(SETS)) || bus.flush_busy !== (k < int'(SETS))) begin
                n_fail++;
                $display("FAIL reset_sweep cycle=%0d req_ready=%b flush_busy=%b required %b/%b",
                         k, bus.req_ready, bus.flush_busy, k >= int'(SETS), k < int'(SETS));
            end
        end
    endtask

    task automatic test_lookup_all();
        for (int s = 0; s < int'(SETS); s++) begin
            bus.req_valid   = 1'b1;
            bus.req_set     = SB'(s);
            bus.req_tag     = TW'(s);
            bus.req_payload = {32'hC0DE_0000, 32'(s)};
            tick();
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_set !== SB'(s) || bus.out_way_valid !== 4'b0 ||
                bus.out_way_dirty !== 4'b0 || bus.out_payload !== {32'hC0DE_0000, 32'(s)}) begin
                n_fail++;
                $display("FAIL lookup_all set=%0d out_valid=%b out_set=%0d way_valid=%b way_dirty=%b required 1/%0d/0000/0000",
                         s, bus.out_valid, bus.out_set, bus.out_way_valid, bus.out_way_dirty, s);
            end
        end
        bus.req_valid = 1'b0;
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_drop out_valid=%b required 0", bus.out_valid);
        end
    endtask

    task automatic test_tag_hit();
        logic [WAYS*TW-1:0] exp_tags;
        exp_tags = '0;
        exp_tags[2*TW +: TW] = 18'h123;
        bus.upd_tag_en = 4'b0100; bus.upd_tag_set = 8'd5; bus.upd_tag = 18'h123; bus.upd_valid = 1'b1;
        tick();
        idle();
        bus.req_valid = 1'b1; bus.req_set = 8'd5; bus.req_tag = 18'h123; bus.req_payload = 64'h5555;
        tick();
        bus.req_valid = 1'b1; bus.req_set = 8'd5; bus.req_tag = 18'h124;
        n_checks++;
        if (bus.out_hit !== 4'b0100 || bus.out_hit_any !== 1'b1) begin
            n_fail++;
            $display("FAIL tag_hit out_hit=%b hit_any=%b required 0100/1", bus.out_hit, bus.out_hit_any);
        end
        n_checks++;
        if (bus.out_way_tag !== exp_tags || bus.out_way_valid !== 4'b0100 || bus.out_payload !== 64'h5555) begin
            n_fail++;
            $display("FAIL tag_fields way_tag=%h way_valid=%b payload=%h required %h/0100/5555",
                     bus.out_way_tag, bus.out_way_valid, bus.out_payload, exp_tags);
        end
        tick();
        bus.req_valid = 1'b1; bus.req_set = 8'd6; bus.req_tag = 18'h123;
        n_checks++;
        if (bus.out_hit !== 4'b0000 || bus.out_hit_any !== 1'b0 || bus.out_way_valid !== 4'b0100) begin
            n_fail++;
            $display("FAIL tag_miss_tag out_hit=%b hit_any=%b way_valid=%b required 0000/0/0100",
                     bus.out_hit, bus.out_hit_any, bus.out_way_valid);
        end
        tick();
        bus.req_valid = 1'b0;
        n_checks++;
        if (bus.out_hit_any !== 1'b0 || bus.out_way_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL tag_miss_set hit_any=%b way_valid=%b required 0/0000", bus.out_hit_any, bus.out_way_valid);
        end
        tick();
    endtask

    task automatic test_read_during_write();
        bus.upd_tag_en = 4'b0001; bus.upd_tag_set = 8'd7; bus.upd_tag = 18'h2AB; bus.upd_valid = 1'b1;
        bus.req_valid = 1'b1; bus.req_set = 8'd7; bus.req_tag = 18'h2AB;
        tick();
        idle();
        n_checks++;
        if (bus.out_way_valid !== 4'b0001 || bus.out_way_tag[0 +: TW] !== 18'h2AB || bus.out_hit !== 4'b0001) begin
            n_fail++;
            $display("FAIL rdw way_valid=%b way0_tag=%h out_hit=%b required 0001/2ab/0001",
                     bus.out_way_valid, bus.out_way_tag[0 +: TW], bus.out_hit);
        end
        tick();
    endtask

    task automatic test_stall_forward();
        bus.req_valid = 1'b1; bus.req_set = 8'd9; bus.req_tag = 18'h55; bus.req_payload = 64'h9999;
        tick();
        bus.stall = 1'b1; bus.req_set = 8'd10; bus.req_payload = 64'hAAAA;
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_set !== 8'd9 || bus.out_payload !== 64'h9999 ||
            bus.req_ready !== 1'b0 || bus.out_way_dirty !== 4'b0) begin
            n_fail++;
            $display("FAIL stall_hold out_valid=%b out_set=%0d payload=%h req_ready=%b way_dirty=%b required 1/9/9999/0/0000",
                     bus.out_valid, bus.out_set, bus.out_payload, bus.req_ready, bus.out_way_dirty);
        end
        bus.upd_dirty_en = 4'b1000; bus.upd_dirty_set = 8'd9; bus.upd_dirty_value = 1'b1;
        tick();
        bus.upd_dirty_en = 4'b0001; bus.upd_dirty_set = 8'd11;
        bus.upd_tag_en = 4'b0010; bus.upd_tag_set = 8'd9; bus.upd_tag = 18'h55; bus.upd_valid = 1'b1;
        n_checks++;
        if (bus.out_way_dirty !== 4'b1000 || bus.out_set !== 8'd9) begin
            n_fail++;
            $display("FAIL fwd_dirty way_dirty=%b out_set=%0d required 1000/9", bus.out_way_dirty, bus.out_set);
        end
        tick();
        bus.upd_dirty_en = '0; bus.upd_tag_en = '0;
        n_checks++;
        if (bus.out_hit !== 4'b0010 || bus.out_way_dirty !== 4'b1000 || bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL fwd_tag out_hit=%b way_dirty=%b out_valid=%b required 0010/1000/1",
                     bus.out_hit, bus.out_way_dirty, bus.out_valid);
        end
        bus.stall = 1'b0; bus.req_valid = 1'b0;
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release out_valid=%b required 0", bus.out_valid);
        end
        bus.req_valid = 1'b1; bus.req_set = 8'd9; bus.req_tag = 18'h55;
        tick();
        bus.req_set = 8'd11; bus.req_tag = 18'h0;
        n_checks++;
        if (bus.out_hit !== 4'b0010 || bus.out_way_dirty !== 4'b1000) begin
            n_fail++;
            $display("FAIL stored_set9 out_hit=%b way_dirty=%b required 0010/1000", bus.out_hit, bus.out_way_dirty);
        end
        tick();
        bus.req_valid = 1'b0;
        n_checks++;
        if (bus.out_way_dirty !== 4'b0001 || bus.out_hit_any !== 1'b0) begin
            n_fail++;
            $display("FAIL stored_set11 way_dirty=%b hit_any=%b required 0001/0", bus.out_way_dirty, bus.out_hit_any);
        end
        tick();
    endtask

    task automatic test_flush();
        logic [SB-1:0] sets [4];
        logic [TW-1:0] tags [4];
        sets = '{8'd5, 8'd7, 8'd9, 8'd11};
        tags = '{18'h123, 18'h2AB, 18'h55, 18'h0};
        bus.flush_req = 1'b1;
        bus.req_valid = 1'b1; bus.req_set = 8'd5; bus.req_tag = 18'h123;
        tick();
        idle();
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_hit !== 4'b0100 || bus.flush_busy !== 1'b1 || bus.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_accept out_valid=%b out_hit=%b flush_busy=%b req_ready=%b required 1/0100/1/0",
                     bus.out_valid, bus.out_hit, bus.flush_busy, bus.req_ready);
        end
        for (int k = 2; k <= int'(SETS) + 1; k++) begin
            bus.flush_req = (k == 100);
            tick();
            bus.flush_req = 1'b0;
            n_checks++;
            if (bus.flush_busy !== (k <= int'(SETS)) || bus.req_ready !== (k > int'(SETS))) begin
                n_fail++;
                $display("FAIL flush_busy cycle=%0d flush_busy=%b req_ready=%b required %b/%b",
                         k, bus.flush_busy, bus.req_ready, k <= int'(SETS), k > int'(SETS));
            end
        end
        for (int i = 0; i < 4; i++) begin
            bus.req_valid = 1'b1; bus.req_set = sets[i]; bus.req_tag = tags[i];
            tick();
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_hit_any !== 1'b0 ||
                bus.out_way_valid !== 4'b0 || bus.out_way_dirty !== 4'b0) begin
                n_fail++;
                $display("FAIL flush_miss set=%0d out_valid=%b hit_any=%b way_valid=%b way_dirty=%b required 1/0/0000/0000",
                         sets[i], bus.out_valid, bus.out_hit_any, bus.out_way_valid, bus.out_way_dirty);
            end
        end
        bus.req_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_sweep();
        bus.upd_tag_en = 4'b0010; bus.upd_tag_set = 8'd200; bus.upd_tag = 18'h77; bus.upd_valid = 1'b1;
        tick();
        idle();
        bus.flush_req = 1'b1;
        tick();
        bus.flush_req = 1'b0;
        repeat (100) tick();
        n_checks++;
        if (dut.u_sweeper.sweep_set !== 8'd100 || bus.flush_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_sweep_pos sweep_set=%0d flush_busy=%b required 100/1", dut.u_sweeper.sweep_set, bus.flush_busy);
        end
        reset = 1'b0;
        repeat (2) tick();
        n_checks++;
        if (dut.u_sweeper.sweep_set !== 8'd0 || bus.flush_busy !== 1'b1 || bus.req_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_sweep_reset sweep_set=%0d flush_busy=%b req_ready=%b out_valid=%b required 0/1/0/0",
                     dut.u_sweeper.sweep_set, bus.flush_busy, bus.req_ready, bus.out_valid);
        end
        reset = 1'b1;
        for (int k = 1; k <= int'(SETS); k++) begin
            tick();
            n_checks++;
            if (bus.req_ready !== (k >= int'(SETS))) begin
                n_fail++;
                $display("FAIL mid_sweep_ready cycle=%0d req_ready=%b required %b", k, bus.req_ready, k >= int'(SETS));
            end
        end
        bus.req_valid = 1'b1; bus.req_set = 8'd200; bus.req_tag = 18'h77;
        tick();
        bus.req_valid = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_way_valid !== 4'b0 || bus.out_hit_any !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_sweep_clear out_valid=%b way_valid=%b hit_any=%b required 1/0000/0",
                     bus.out_valid, bus.out_way_valid, bus.out_hit_any);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [WAYS*TW-1:0] exp_tags;
        exp_tags = '0;
        exp_tags[3*TW +: TW] = 18'h3FFFF;
        bus.upd_tag_en = 4'b1000; bus.upd_tag_set = 8'd20; bus.upd_tag = 18'h3FFFF; bus.upd_valid = 1'b1;
        tick();
        bus.upd_tag_en = 4'b0001; bus.upd_tag_set = 8'd255; bus.upd_tag = 18'h0;
        tick();
        idle();
        bus.req_valid = 1'b1; bus.req_set = 8'd20; bus.req_tag = 18'h3FFFF; bus.req_payload = 64'h20;
        tick();
        bus.req_set = 8'd255; bus.req_tag = 18'h0; bus.req_payload = 64'hFF;
        n_checks++;
        if (bus.out_hit !== 4'b1000 || bus.out_way_tag !== exp_tags || bus.out_payload !== 64'h20) begin
            n_fail++;
            $display("FAIL b2b_set20 out_hit=%b way_tag=%h payload=%h required 1000/%h/20",
                     bus.out_hit, bus.out_way_tag, bus.out_payload, exp_tags);
        end
        tick();
        bus.req_set = 8'd0; bus.req_tag = 18'h0; bus.req_payload = 64'h0;
        n_checks++;
        if (bus.out_hit !== 4'b0001 || bus.out_set !== 8'd255 || bus.out_payload !== 64'hFF) begin
            n_fail++;
            $display("FAIL b2b_set255 out_hit=%b out_set=%0d payload=%h required 0001/255/ff",
                     bus.out_hit, bus.out_set, bus.out_payload);
        end
        tick();
        bus.req_valid = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_hit_any !== 1'b0 || bus.out_set !== 8'd0) begin
            n_fail++;
            $display("FAIL b2b_set0 out_valid=%b hit_any=%b out_set=%0d required 1/0/0",
                     bus.out_valid, bus.out_hit_any, bus.out_set);
        end
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.out_hit_any !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drain out_valid=%b hit_any=%b required 0/0", bus.out_valid, bus.out_hit_any);
        end
    endtask

    initial begin
        test_reset();
        test_lookup_all();
        test_tag_hit();
        test_read_during_write();
        test_stall_forward();
        test_flush();
        test_reset_mid_sweep();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
